// File: rtl/qerv_dbus_ctrl.sv
// qerv data-bus master: turns a core load/store request into a single Wishbone-style
// transaction, replicates store data across byte lanes, and streams aligned,
// sign/zero-extended load data back to the core BITS_PER_CYCLE bits at a time.
module qerv_dbus_ctrl #(
  parameter int unsigned BITS_PER_CYCLE = 4,
  parameter int unsigned LB             = $clog2(BITS_PER_CYCLE)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_cmd_valid,
  input  logic                      i_we,
  input  logic [1:0]                i_size,
  input  logic                      i_signed,
  input  logic [31:0]               i_adr,
  input  logic [1:0]                i_lsb,
  input  logic [31:0]               i_wdata,
  output logic                      o_busy,
  output logic [31:0]               o_wb_adr,
  output logic [31:0]               o_wb_dat,
  output logic [3:0]                o_wb_sel,
  output logic                      o_wb_we,
  output logic                      o_wb_cyc,
  input  logic [31:0]               i_wb_rdt,
  input  logic                      i_wb_ack,
  output logic                      o_rdy,
  output logic                      o_misalign,
  input  logic                      i_rd_en,
  output logic [BITS_PER_CYCLE-1:0] o_rd_q
);

  // Chunk counter spans 32/BITS_PER_CYCLE consumes.
  localparam int unsigned CntW = 5 - LB;
  localparam logic [CntW-1:0] CntLast = CntW'(32 / BITS_PER_CYCLE - 1);

  typedef enum logic [1:0] {StIdle, StBus, StShift} state_e;

  state_e            state_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [1:0]        lsb_q;
  logic [31:0]       rd_data_q;
  logic [CntW-1:0]   cnt_q;

  logic              misalign_c;
  logic [3:0]        sel_c;
  logic [31:0]       dat_c;
  logic [31:0]       rdt_shifted;
  logic [31:0]       ext_c;

  // Word address low bits are dropped by design.
  logic unused_adr;
  assign unused_adr = ^i_adr[1:0];

  // Request decode: alignment check, byte enables and lane-replicated store data.
  always_comb begin
    misalign_c = 1'b0;
    sel_c      = 4'b1111;
    dat_c      = i_wdata;
    case (i_size)
      2'b00: begin
        sel_c = 4'b0001 << i_lsb;
        dat_c = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        misalign_c = i_lsb[0];
        sel_c      = 4'b0011 << i_lsb;
        dat_c      = {2{i_wdata[15:0]}};
      end
      default: begin
        misalign_c = (i_lsb != 2'b00);
      end
    endcase
  end

  // Load data alignment and sign/zero extension.
  always_comb begin
    rdt_shifted = i_wb_rdt >> {lsb_q, 3'b000};
    case (size_q)
      2'b00:   ext_c = {{24{signed_q & rdt_shifted[7]}}, rdt_shifted[7:0]};
      2'b01:   ext_c = {{16{signed_q & rdt_shifted[15]}}, rdt_shifted[15:0]};
      default: ext_c = rdt_shifted;
    endcase
  end

  // Transaction FSM with registered bus and handshake outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      o_wb_adr   <= '0;
      o_wb_dat   <= '0;
      o_wb_sel   <= '0;
      o_wb_we    <= 1'b0;
      o_wb_cyc   <= 1'b0;
      o_rdy      <= 1'b0;
      o_misalign <= 1'b0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      lsb_q      <= '0;
      rd_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      o_rdy      <= 1'b0;
      o_misalign <= 1'b0;
      case (state_q)
        StIdle: begin
          if (i_cmd_valid) begin
            if (misalign_c) begin
              o_misalign <= 1'b1;
            end else begin
              state_q  <= StBus;
              o_wb_cyc <= 1'b1;
              o_wb_we  <= i_we;
              o_wb_adr <= {i_adr[31:2], 2'b00};
              o_wb_sel <= sel_c;
              o_wb_dat <= dat_c;
              size_q   <= i_size;
              signed_q <= i_signed;
              lsb_q    <= i_lsb;
            end
          end
        end
        StBus: begin
          if (i_wb_ack) begin
            o_wb_cyc <= 1'b0;
            o_rdy    <= 1'b1;
            if (o_wb_we) begin
              state_q <= StIdle;
            end else begin
              state_q   <= StShift;
              rd_data_q <= ext_c;
              cnt_q     <= '0;
            end
          end
        end
        StShift: begin
          if (i_rd_en) begin
            rd_data_q <= rd_data_q >> BITS_PER_CYCLE;
            cnt_q     <= cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_busy = (state_q != StIdle);
  assign o_rd_q = (state_q == StShift) ? rd_data_q[BITS_PER_CYCLE-1:0] : '0;

endmodule

// File: tb/tb_qerv_dbus_ctrl.sv
// Directed bench for qerv_dbus_ctrl with a scoreboard of expected bus requests and
// expected streamed load values.
module tb_qerv_dbus_ctrl;

  localparam int unsigned B = 4;
  localparam int unsigned N = 32 / B;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_cmd_valid = 1'b0;
  logic          i_we = 1'b0;
  logic [1:0]    i_size = '0;
  logic          i_signed = 1'b0;
  logic [31:0]   i_adr = '0;
  logic [1:0]    i_lsb = '0;
  logic [31:0]   i_wdata = '0;
  logic          o_busy;
  logic [31:0]   o_wb_adr;
  logic [31:0]   o_wb_dat;
  logic [3:0]    o_wb_sel;
  logic          o_wb_we;
  logic          o_wb_cyc;
  logic [31:0]   i_wb_rdt = '0;
  logic          i_wb_ack = 1'b0;
  logic          o_rdy;
  logic          o_misalign;
  logic          i_rd_en = 1'b0;
  logic [B-1:0]  o_rd_q;

  qerv_dbus_ctrl #(.BITS_PER_CYCLE(B)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_cmd_valid (i_cmd_valid),
    .i_we        (i_we),
    .i_size      (i_size),
    .i_signed    (i_signed),
    .i_adr       (i_adr),
    .i_lsb       (i_lsb),
    .i_wdata     (i_wdata),
    .o_busy      (o_busy),
    .o_wb_adr    (o_wb_adr),
    .o_wb_dat    (o_wb_dat),
    .o_wb_sel    (o_wb_sel),
    .o_wb_we     (o_wb_we),
    .o_wb_cyc    (o_wb_cyc),
    .i_wb_rdt    (i_wb_rdt),
    .i_wb_ack    (i_wb_ack),
    .o_rdy       (o_rdy),
    .o_misalign  (o_misalign),
    .i_rd_en     (i_rd_en),
    .o_rd_q      (o_rd_q)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        we;
  } bus_t;

  bus_t        exp_bus_q[$];
  logic [31:0] exp_rd_q[$];

  int checks = 0;
  int errors = 0;
  int rdy_cnt = 0;

  logic        cur_we;
  logic [1:0]  cur_size;
  logic        cur_sgn;
  logic [1:0]  cur_lsb;

  always @(posedge i_clk) if (o_rdy) rdy_cnt <= rdy_cnt + 1;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] load_model(input logic [1:0] size, input logic sgn,
                                             input logic [1:0] lsb, input logic [31:0] rdt);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdt[8*lsb +: 8];
    h = rdt[8*lsb +: 16];
    if (size == 2'b00) return sgn ? {{24{b[7]}}, b} : {24'h0, b};
    if (size == 2'b01) return sgn ? {{16{h[15]}}, h} : {16'h0, h};
    return rdt;
  endfunction

  // Drives a one-cycle request; returns one cycle later.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] adr, input logic [1:0] lsb, input logic [31:0] wdata);
    bus_t e;
    logic mis;
    mis = (size == 2'b01 && lsb[0]) || (size[1] && lsb != 2'b00);
    if (!mis) begin
      e.adr = {adr[31:2], 2'b00};
      e.we  = we;
      case (size)
        2'b00:   begin e.sel = 4'b0001 << lsb; e.dat = {4{wdata[7:0]}}; end
        2'b01:   begin e.sel = 4'b0011 << lsb; e.dat = {2{wdata[15:0]}}; end
        default: begin e.sel = 4'b1111; e.dat = wdata; end
      endcase
      exp_bus_q.push_back(e);
    end
    cur_we = we; cur_size = size; cur_sgn = sgn; cur_lsb = lsb;
    i_cmd_valid = 1'b1; i_we = we; i_size = size; i_signed = sgn;
    i_adr = adr; i_lsb = lsb; i_wdata = wdata;
    step();
    i_cmd_valid = 1'b0; i_we = 1'b0; i_size = '0; i_signed = 1'b0;
    i_adr = '0; i_lsb = '0; i_wdata = '0;
  endtask

  task automatic check_bus(input string tag);
    bus_t e;
    if (exp_bus_q.size() == 0) begin
      check({tag, "_bus_queue_empty"}, 32'(o_wb_cyc), 32'hFFFF_FFFF);
      return;
    end
    e = exp_bus_q.pop_front();
    check({tag, "_cyc"}, 32'(o_wb_cyc), 32'd1);
    check({tag, "_adr"}, o_wb_adr, e.adr);
    check({tag, "_sel"}, 32'(o_wb_sel), 32'(e.sel));
    check({tag, "_dat"}, o_wb_dat, e.dat);
    check({tag, "_we"}, 32'(o_wb_we), 32'(e.we));
  endtask

  // Holds off ack for 'waits' cycles, then acks for one cycle; counts cyc-high cycles.
  task automatic bus_ack(input int waits, input logic [31:0] rdt, output int ncyc);
    ncyc = 0;
    for (int w = 0; w < waits; w++) begin
      if (o_wb_cyc) ncyc++;
      step();
    end
    if (o_wb_cyc) ncyc++;
    if (!cur_we) exp_rd_q.push_back(load_model(cur_size, cur_sgn, cur_lsb, rdt));
    i_wb_ack = 1'b1;
    i_wb_rdt = rdt;
    step();
    i_wb_ack = 1'b0;
    i_wb_rdt = '0;
  endtask

  task automatic read_stream(input string tag, input bit stall);
    logic [31:0] exp;
    logic [31:0] val;
    if (exp_rd_q.size() == 0) begin
      check({tag, "_rd_queue_empty"}, 32'(o_busy), 32'hFFFF_FFFF);
      return;
    end
    exp = exp_rd_q.pop_front();
    val = '0;
    for (int i = 0; i < N; i++) begin
      if (stall && i == 2) begin
        step();
        step();
        check({tag, "_stall_hold"}, 32'(o_rd_q), 32'(exp[i*B +: B]));
        check({tag, "_stall_busy"}, 32'(o_busy), 32'd1);
      end
      val[i*B +: B] = o_rd_q;
      i_rd_en = 1'b1;
      step();
      i_rd_en = 1'b0;
    end
    check({tag, "_data"}, val, exp);
    check({tag, "_busy_done"}, 32'(o_busy), 32'd0);
    check({tag, "_rdq_idle"}, 32'(o_rd_q), 32'd0);
  endtask

  initial begin
    int ncyc;
    int r0;
    logic [31:0] drop;

    // Reset values
    #12;
    check("rst_cyc", 32'(o_wb_cyc), 0);
    check("rst_we", 32'(o_wb_we), 0);
    check("rst_rdy", 32'(o_rdy), 0);
    check("rst_mis", 32'(o_misalign), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_adr", o_wb_adr, 0);
    check("rst_dat", o_wb_dat, 0);
    check("rst_sel", 32'(o_wb_sel), 0);
    check("rst_rdq", 32'(o_rd_q), 0);
    i_rst_n = 1'b1;
    step();

    // 1: byte store with two wait states
    r0 = rdy_cnt;
    issue(1'b1, 2'b00, 1'b0, 32'h0000_0100, 2'd2, 32'h0000_00A5);
    check_bus("t1");
    check("t1_busy", 32'(o_busy), 1);
    bus_ack(2, 32'h0, ncyc);
    check("t1_cyc_cycles", 32'(ncyc), 3);
    check("t1_rdy", 32'(o_rdy), 1);
    check("t1_cyc_drop", 32'(o_wb_cyc), 0);
    step();
    check("t1_rdy_end", 32'(o_rdy), 0);
    check("t1_busy_end", 32'(o_busy), 0);
    check("t1_rdy_count", 32'(rdy_cnt - r0), 1);

    // 2: signed byte load, lsb=3
    issue(1'b0, 2'b00, 1'b1, 32'h0000_0204, 2'd3, 32'h0);
    check_bus("t2");
    bus_ack(1, 32'h80FF_FFFF, ncyc);
    check("t2_rdy", 32'(o_rdy), 1);
    check("t2_chunk0", 32'(o_rd_q), 32'h0);
    read_stream("t2", 1'b0);

    // 3: unsigned half load, lsb=2, with a stall
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0308, 2'd2, 32'h0);
    check_bus("t3");
    bus_ack(0, 32'hBEEF_1234, ncyc);
    read_stream("t3", 1'b1);

    // 4: misaligned half load and word store
    r0 = rdy_cnt;
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0700, 2'd1, 32'h0);
    check("t4a_mis", 32'(o_misalign), 1);
    check("t4a_cyc", 32'(o_wb_cyc), 0);
    check("t4a_busy", 32'(o_busy), 0);
    step();
    check("t4a_mis_end", 32'(o_misalign), 0);
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0800, 2'd2, 32'hDEAD_BEEF);
    check("t4b_mis", 32'(o_misalign), 1);
    check("t4b_cyc", 32'(o_wb_cyc), 0);
    step();
    check("t4b_cyc_later", 32'(o_wb_cyc), 0);
    step();
    check("t4_no_rdy", 32'(rdy_cnt - r0), 0);

    // 5: reset mid-BUS and mid-SHIFT, then a clean transaction
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0400, 2'd2, 32'h1234_5678);
    check_bus("t5a");
    i_rst_n = 1'b0;
    #1;
    check("t5a_cyc", 32'(o_wb_cyc), 0);
    check("t5a_busy", 32'(o_busy), 0);
    step();
    i_rst_n = 1'b1;
    issue(1'b0, 2'b00, 1'b1, 32'h0000_0500, 2'd1, 32'h0);
    check_bus("t5b");
    bus_ack(1, 32'h0000_F000, ncyc);
    i_rd_en = 1'b1;
    step();
    step();
    i_rd_en = 1'b0;
    check("t5b_busy", 32'(o_busy), 1);
    i_rst_n = 1'b0;
    #1;
    check("t5b_busy_rst", 32'(o_busy), 0);
    check("t5b_rdq_rst", 32'(o_rd_q), 0);
    drop = exp_rd_q.pop_front();
    step();
    i_rst_n = 1'b1;
    issue(1'b0, 2'b10, 1'b1, 32'h0000_0600, 2'd0, 32'h0);
    check_bus("t5c");
    bus_ack(0, 32'h1234_5678, ncyc);
    read_stream("t5c", 1'b0);

    // 6: zero-wait ack, ignored command while busy, stray ack/rd_en in idle
    r0 = rdy_cnt;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_2000, 2'd0, 32'h0);
    check_bus("t6");
    i_cmd_valid = 1'b1; i_we = 1'b1; i_adr = 32'h0000_3000; i_wdata = 32'h77;
    bus_ack(0, 32'hCAFE_F00D, ncyc);
    check("t6_cyc_cycles", 32'(ncyc), 1);
    check("t6_rdy", 32'(o_rdy), 1);
    check("t6_cyc_drop", 32'(o_wb_cyc), 0);
    step();
    i_cmd_valid = 1'b0; i_we = 1'b0; i_adr = '0; i_wdata = '0;
    check("t6_cyc_ignored", 32'(o_wb_cyc), 0);
    read_stream("t6", 1'b0);
    check("t6_adr_kept", o_wb_adr, 32'h0000_2000);
    i_wb_ack = 1'b1;
    i_rd_en = 1'b1;
    step();
    i_wb_ack = 1'b0;
    i_rd_en = 1'b0;
    check("t6_stray_cyc", 32'(o_wb_cyc), 0);
    check("t6_stray_busy", 32'(o_busy), 0);
    check("t6_stray_rdq", 32'(o_rd_q), 0);
    step();
    check("t6_stray_rdy", 32'(o_rdy), 0);
    check("t6_rdy_count", 32'(rdy_cnt - r0), 1);
    check("bus_queue_drained", 32'(exp_bus_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
